protobuf_varint_decoder: RTL

- Streaming base-128 varint decoder; sits directly upstream of the protobuf field parser.
- Consumes the raw wire byte stream (keys, varint payloads) one byte per cycle.
- Emits one decoded 64-bit value per varint, plus byte count and error flags.
- Drives the parser's key slicing (wire type / field number) and varint field values.

---
 rtl/protobuf_pkg.sv | 19 +
 rtl/protobuf_varint_decoder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/protobuf_pkg.sv
// Shared types and constants for the protobuf wire-format front end.
package protobuf_pkg;

    localparam int MAX_VARINT_BYTES = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SKIP
    } varint_state_t;

    typedef logic [63:0] varint_value_t;

    // sint32/sint64 decode: (raw >> 1) ^ -(raw & 1)
    function automatic varint_value_t ZIGZAG_DECODE(input varint_value_t raw);
        return (raw >> 1) ^ {64{raw[0]}};
    endfunction

endpackage

// File: rtl/protobuf_varint_decoder.sv
// Streaming base-128 varint decoder, one wire byte per cycle, one-deep output register.
// Optional zigzag (sint) decode is enabled with `define PROTO_VARINT_ZIGZAG_EN.
module protobuf_varint_decoder
    import protobuf_pkg::*;
#(
    parameter int MAX_BYTES = MAX_VARINT_BYTES,
    parameter int VALUE_W   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [VALUE_W-1:0] m_value,
    output logic [3:0]         m_nbytes,
    output logic               m_last,
    output logic               m_overflow,
    output logic               err_too_long,
    output logic               err_truncated
`ifdef PROTO_VARINT_ZIGZAG_EN
    ,
    input  logic               s_zigzag,
    output logic               m_zigzag
`endif
);

    // Wide enough to hold every group shifted into place, plus the dropped high bits.
    localparam int ACC_W = (7 * MAX_BYTES > VALUE_W) ? 7 * MAX_BYTES : VALUE_W + 1;
    localparam logic [3:0] LAST_IDX = 4'(MAX_BYTES - 1);

    varint_state_t       state_reg;
    logic [VALUE_W-1:0]  acc_reg;
    logic [3:0]          count_reg;
    logic                ovf_reg;

    logic                accept;
    logic                cont;
    logic [ACC_W-1:0]    byte_bits;
    logic [VALUE_W-1:0]  acc_next;
    logic [VALUE_W-1:0]  value_next;
    logic                ovf_next;

    assign s_ready   = rst_n && !(m_valid && !m_ready);
    assign accept    = s_valid && s_ready;
    assign cont      = s_data[7];
    assign byte_bits = ACC_W'(s_data[6:0]) << (7 * int'(count_reg));
    assign acc_next  = acc_reg | byte_bits[VALUE_W-1:0];
    assign ovf_next  = ovf_reg || (byte_bits[ACC_W-1:VALUE_W] != '0);

`ifdef PROTO_VARINT_ZIGZAG_EN
    logic zz_reg;
    logic zz_cur;

    // The flag belongs to the first byte; later bytes reuse the captured copy.
    assign zz_cur     = (state_reg == IDLE) ? s_zigzag : zz_reg;
    assign value_next = zz_cur ? VALUE_W'(ZIGZAG_DECODE(varint_value_t'(acc_next))) : acc_next;
`else
    assign value_next = acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            m_valid       <= 1'b0;
            m_value       <= '0;
            m_nbytes      <= '0;
            m_last        <= 1'b0;
            m_overflow    <= 1'b0;
            err_too_long  <= 1'b0;
            err_truncated <= 1'b0;
`ifdef PROTO_VARINT_ZIGZAG_EN
            zz_reg        <= 1'b0;
            m_zigzag      <= 1'b0;
`endif
        end else begin
            err_too_long  <= 1'b0;
            err_truncated <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
`ifdef PROTO_VARINT_ZIGZAG_EN
            if (accept && state_reg == IDLE) begin
                zz_reg <= s_zigzag;
            end
`endif
            if (accept) begin
                case (state_reg)
                    IDLE, ACCUM: begin
                        // count_reg is zero in IDLE, so both states share one path.
                        acc_reg   <= '0;
                        count_reg <= '0;
                        ovf_reg   <= 1'b0;
                        state_reg <= IDLE;
                        if (!cont) begin
                            m_valid    <= 1'b1;
                            m_value    <= value_next;
                            m_nbytes   <= count_reg + 4'd1;
                            m_last     <= s_last;
                            m_overflow <= ovf_next;
`ifdef PROTO_VARINT_ZIGZAG_EN
                            m_zigzag   <= zz_cur;
`endif
                        end else if (count_reg == LAST_IDX) begin
                            err_too_long <= 1'b1;
                            state_reg    <= s_last ? IDLE : SKIP;
                        end else if (s_last) begin
                            err_truncated <= 1'b1;
                        end else begin
                            acc_reg   <= acc_next;
                            count_reg <= count_reg + 4'd1;
                            ovf_reg   <= ovf_next;
                            state_reg <= ACCUM;
                        end
                    end
                    SKIP: begin
                        if (!cont || s_last) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
